// File: rtl/jt49_env_gen_pkg.sv
// Shared constants for the JT49 envelope generator: control-bit positions,
// shape-FSM state encoding and default widths.
package jt49_env_gen_pkg;
    localparam int PW_DEF    = 16;
    localparam int STEPW_DEF = 5;

    localparam int CONT = 3;
    localparam int ATT  = 2;
    localparam int ALT  = 1;
    localparam int HOLD = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } env_st_e;
endpackage

// File: rtl/jt49_env_div.sv
// Envelope prescaler: counts cen256 pulses while running and emits a one-cycle
// tick every max(period,1) pulses. clr restarts the count from zero.
module jt49_env_div #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [PW-1:0] period,
    input  logic          clr,
    input  logic          run,
    output logic          tick
);
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW:0]   nxt, pmax;

    // Compare against cnt+1 so a period lowered below the current count ticks at once.
    always_comb begin
        pmax  = (period == '0) ? (PW+1)'(1) : {1'b0, period};
        nxt   = {1'b0, cnt_q} + (PW+1)'(1);
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run && cen) begin
            if (nxt >= pmax) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = nxt[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/jt49_env_gen.sv
// JT49 envelope generator: steps a 32-level envelope through the AY/YM shapes
// selected by {CONT,ATT,ALT,HOLD}, paced by the cen256-driven prescaler.
module jt49_env_gen
    import jt49_env_gen_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int STEPW = STEPW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen256,
    input  logic [PW-1:0]    period,
    input  logic [3:0]       ctrl,
    input  logic             restart,
    output logic [STEPW-1:0] env,
    output logic             env_hold
);
    logic [3:0]       ctrl_q, ctrl_d;
    logic [STEPW-1:0] step_q, step_d;
    logic             inv_q, inv_d;
    env_st_e          st_q, st_d;
    logic             tick;
    logic [STEPW-1:0] env_q;
    logic             hold_q;

    jt49_env_div #(.PW(PW)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen256),
        .period (period),
        .clr    (restart),
        .run    (st_q == ST_RUN),
        .tick   (tick)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        step_d = step_q;
        inv_d  = inv_q;
        st_d   = st_q;
        if (restart) begin
            ctrl_d = ctrl;
            step_d = '0;
            inv_d  = ~ctrl[ATT];
            st_d   = ST_RUN;
        end else if (st_q == ST_RUN && tick) begin
            if (!(&step_q)) begin
                step_d = step_q + 1'b1;
            end else if (!ctrl_q[CONT]) begin
                // one-shot shapes always settle at level 0
                st_d  = ST_HOLD;
                inv_d = 1'b1;
            end else if (ctrl_q[HOLD]) begin
                st_d  = ST_HOLD;
                inv_d = inv_q ^ ctrl_q[ALT];
            end else begin
                step_d = '0;
                if (ctrl_q[ALT]) inv_d = ~inv_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            step_q <= '0;
            inv_q  <= 1'b0;
            st_q   <= ST_HOLD;
            env_q  <= '0;
            hold_q <= 1'b1;
        end else begin
            ctrl_q <= ctrl_d;
            step_q <= step_d;
            inv_q  <= inv_d;
            st_q   <= st_d;
            env_q  <= inv_d ? ~step_d : step_d;
            hold_q <= (st_d == ST_HOLD);
        end
    end

    assign env      = env_q;
    assign env_hold = hold_q;
endmodule

// File: tb/tb_jt49_env_gen.sv
// Self-checking bench for jt49_env_gen: per-cycle scoreboard against a
// closed-form shape model, a table of end-state vectors, and corner sequences.
module tb_jt49_env_gen;
    logic        clk = 1'b0;
    logic        rst_n, cen256, restart;
    logic [15:0] period;
    logic [3:0]  ctrl;
    logic [4:0]  env;
    logic        env_hold;

    always #5 clk = ~clk;

    jt49_env_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen256   (cen256),
        .period   (period),
        .ctrl     (ctrl),
        .restart  (restart),
        .env      (env),
        .env_hold (env_hold)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [15:0] period;
        int          ncen;
        logic [4:0]  env;
        logic        hold;
    } vec_t;

    typedef struct {
        logic [4:0] env;
        logic       hold;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    int         m_n, m_pcnt;
    bit         m_run, m_fresh;
    logic [3:0] m_ctrl;

    // Level after n steps since restart, derived from the shape definitions.
    function automatic logic [4:0] shape(input logic [3:0] c, input int n);
        int r;
        bit up;
        r = n % 32;
        if (!c[3])
            return (n >= 32) ? 5'd0 : (c[2] ? 5'(r) : 5'(31 - r));
        if (c[0])
            return (n >= 32) ? ((c[2] ^ c[1]) ? 5'd31 : 5'd0) : (c[2] ? 5'(r) : 5'(31 - r));
        if (c[1]) begin
            up = c[2] ^ (((n / 32) % 2) == 1);
            return up ? 5'(r) : 5'(31 - r);
        end
        return c[2] ? 5'(r) : 5'(31 - r);
    endfunction

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got hold=%0b env=%0d, expected hold=%0b env=%0d",
                     nm, got[5], got[4:0], exp[5], exp[4:0]);
        end
    endtask

    // One clock: drive inputs, advance the model, push its prediction, then compare after the edge.
    task automatic cyc(input bit c, input bit rs, input string nm);
        exp_t e;
        int   pm;
        cen256  = c;
        restart = rs;
        if (!rst_n) begin
            m_fresh = 1; m_run = 0; m_n = 0; m_pcnt = 0;
        end else if (rs) begin
            m_ctrl = ctrl; m_n = 0; m_pcnt = 0; m_run = 1; m_fresh = 0;
        end else if (m_run && c) begin
            pm = (period == 16'd0) ? 1 : int'(period);
            if (m_pcnt + 1 >= pm) begin
                m_pcnt = 0;
                m_n++;
                if ((!m_ctrl[3] || m_ctrl[0]) && m_n >= 32) m_run = 0;
            end else begin
                m_pcnt++;
            end
        end
        e.env  = m_fresh ? 5'd0 : shape(m_ctrl, m_n);
        e.hold = !m_run;
        e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check(e.name, {env_hold, env}, {e.hold, e.env});
        cen256  = 1'b0;
        restart = 1'b0;
    endtask

    task automatic pulses(input int k, input string nm);
        for (int i = 0; i < k; i++) begin
            cyc(1'b1, 1'b0, nm);
            cyc(1'b0, 1'b0, nm);
        end
    endtask

    task automatic do_restart(input logic [3:0] c, input logic [15:0] p);
        ctrl   = c;
        period = p;
        cyc(1'b0, 1'b1, "restart");
    endtask

    vec_t       tbl[14];
    logic [4:0] tr0[80], tr1[80];

    initial begin
        tbl[0]  = '{4'b1100, 16'd1,   0, 5'd0,  1'b0};
        tbl[1]  = '{4'b1100, 16'd1,   5, 5'd5,  1'b0};
        tbl[2]  = '{4'b1100, 16'd1,  33, 5'd1,  1'b0};
        tbl[3]  = '{4'b0000, 16'd3,   0, 5'd31, 1'b0};
        tbl[4]  = '{4'b0000, 16'd3,   9, 5'd28, 1'b0};
        tbl[5]  = '{4'b0000, 16'd3,  96, 5'd0,  1'b1};
        tbl[6]  = '{4'b0000, 16'd3, 200, 5'd0,  1'b1};
        tbl[7]  = '{4'b1110, 16'd0,  40, 5'd23, 1'b0};
        tbl[8]  = '{4'b1101, 16'd2,  64, 5'd31, 1'b1};
        tbl[9]  = '{4'b1111, 16'd1,  40, 5'd0,  1'b1};
        tbl[10] = '{4'b1000, 16'd1,  35, 5'd28, 1'b0};
        tbl[11] = '{4'b1011, 16'd1,  32, 5'd31, 1'b1};
        tbl[12] = '{4'b0100, 16'd1,  32, 5'd0,  1'b1};
        tbl[13] = '{4'b0100, 16'd1,  31, 5'd31, 1'b0};

        rst_n = 1'b0; cen256 = 1'b0; restart = 1'b0; period = 16'd1; ctrl = 4'd0;
        m_ctrl = 4'd0; m_fresh = 1; m_run = 0; m_n = 0; m_pcnt = 0;
        cyc(1'b0, 1'b0, "reset");
        cyc(1'b1, 1'b1, "reset_over_restart");
        rst_n = 1'b1;

        // No restart since reset: cen256 must not move anything.
        pulses(1000, "idle_after_reset");

        foreach (tbl[i]) begin
            do_restart(tbl[i].ctrl, tbl[i].period);
            pulses(tbl[i].ncen, $sformatf("vec%0d_trace", i));
            check($sformatf("vec%0d_end", i), {env_hold, env}, {tbl[i].hold, tbl[i].env});
        end

        // period 0 and period 1 must give the same triangle trace.
        do_restart(4'b1110, 16'd0);
        for (int i = 0; i < 80; i++) begin pulses(1, "tri_p0"); tr0[i] = env; end
        do_restart(4'b1110, 16'd1);
        for (int i = 0; i < 80; i++) begin pulses(1, "tri_p1"); tr1[i] = env; end
        for (int i = 0; i < 80; i += 8) check($sformatf("tri_p0_vs_p1_%0d", i), {1'b0, tr0[i]}, {1'b0, tr1[i]});

        // Restart landing on the step==31 tick wins, and the prescaler restarts from 0.
        do_restart(4'b1100, 16'd3);
        pulses(93, "pre_coincide");
        check("at_step31", {env_hold, env}, {1'b0, 5'd31});
        pulses(2, "pre_coincide_cnt");
        ctrl = 4'b0000;
        cyc(1'b1, 1'b1, "restart_vs_tick");
        check("restart_wins", {env_hold, env}, {1'b0, 5'd31});
        pulses(2, "after_restart_cnt");
        check("cnt_cleared", {env_hold, env}, {1'b0, 5'd31});
        pulses(1, "after_restart_tick");
        check("first_step_down", {env_hold, env}, {1'b0, 5'd30});

        // Lowering period below the running count ticks on the next cen256.
        do_restart(4'b1100, 16'd5);
        pulses(2, "pre_period_change");
        period = 16'd2;
        pulses(1, "period_change");
        check("period_change_tick", {env_hold, env}, {1'b0, 5'd1});

        // Reset mid-ramp overrides a same-cycle cen256 and restart.
        do_restart(4'b1100, 16'd1);
        pulses(10, "pre_reset");
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, "reset_mid_ramp");
        check("reset_mid_ramp_state", {env_hold, env}, {1'b1, 5'd0});
        rst_n = 1'b1;
        pulses(5, "post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
